// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: the all-off segment
// pattern, the scan FSM state type and the hex-to-segment table.
package seg7_pkg;

  // Active-low {dp,g,f,e,d,c,b,a}: every segment dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // 7-bit active-low {g,f,e,d,c,b,a} glyph for a hex nibble, dp excluded.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: nibble + decimal point -> active-low segments.
// blank_digit_i darkens the whole digit (used for leading-zero suppression).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_digit_i,
  output logic [7:0] seg_o
);

  // dp enable is active-high on the input, segment lines are active-low.
  assign seg_o = blank_digit_i ? SEG_OFF : {~dp_i, hex_to_seg(nibble_i)};

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver. Each digit slot lasts
// SCAN_DIV clocks; the first DEAD_CYCLES of a slot keep all anodes off to
// suppress ghosting. New data is double-buffered and only swapped into the
// active buffer on frame_done, so a frame never mixes old and new digits.
//
// Optional build macro LEADING_ZERO_BLANK_EN: darkens leading zero digits
// (never digit 0, never a digit with its decimal point lit).
//
// Outputs are registered from next-state values so that anodes/segments in
// any cycle correspond to the prescaler/index/state held in that same cycle.
// DEAD_CYCLES is assumed to be at least 1 and SCAN_DIV > DEAD_CYCLES + 1.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    data_load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              segments,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(SCAN_DIV - 1);
  localparam logic [PSC_W-1:0] DEAD_LAST = PSC_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan timing state
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_t      state_q, state_d;
  logic             wrap;

  // Double buffer
  logic [DW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [DW-1:0]         pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic                  swap;

  // Registered outputs
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]            segs_q, segs_d;
  logic                  frame_done_q, frame_done_d;

  // Selected digit feeding the decoder
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  lzb_sel;
  logic [NUM_DIGITS-1:0] lzb;
  logic [7:0]            dec_seg;

  // Prescaler, digit index and DEAD/DRIVE sequencing
  always_comb begin
    wrap    = (psc_q == PSC_LAST);
    psc_d   = wrap ? '0 : psc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    state_d = state_q;
    case (state_q)
      DEAD:    if (psc_q == DEAD_LAST) state_d = DRIVE;
      DRIVE:   if (wrap)               state_d = DEAD;
      default: state_d = DEAD;
    endcase
    // High during the last cycle of the last slot, i.e. the wrap out of it.
    frame_done_d = (psc_d == PSC_LAST) && (idx_d == IDX_LAST);
  end

  // Buffer swap on frame_done; a load in the same cycle lands in pending only
  always_comb begin
    swap        = frame_done_q & pending_q;
    act_data_d  = swap ? pend_data_q : act_data_q;
    act_dp_d    = swap ? pend_dp_q   : act_dp_q;
    pend_data_d = data_load ? data  : pend_data_q;
    pend_dp_d   = data_load ? dp_in : pend_dp_q;
    pending_d   = data_load | (pending_q & ~swap);
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark when it and everything to its left is zero, its dp is
  // off, and it is not the rightmost digit (so "0" still shows as 0).
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lzb        = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (act_data_d[4*i +: 4] == 4'h0);
      lzb[i]     = zero_above & ~act_dp_d[i] & (i != 0);
    end
  end
`else
  assign lzb = '0;
`endif

  // Pick the digit that will be on screen next cycle
  always_comb begin
    nib_sel = '0;
    dp_sel  = 1'b0;
    lzb_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel = act_data_d[4*i +: 4];
        dp_sel  = act_dp_d[i];
        lzb_sel = lzb[i];
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i      (nib_sel),
    .dp_i          (dp_sel),
    .blank_digit_i (lzb_sel),
    .seg_o         (dec_seg)
  );

  // Next anode/segment pattern: one low anode only while driving
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anodes_d[i] = !((state_d == DRIVE) && (idx_d == IDX_W'(i)));
    end
    segs_d = (state_d == DRIVE) ? dec_seg : SEG_OFF;
  end

  // Scan counters and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      idx_q   <= '0;
      state_q <= DEAD;
    end else begin
      psc_q   <= psc_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Active and pending display buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
    end else begin
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pending_q   <= pending_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodes_q     <= '1;
      segs_q       <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      anodes_q     <= anodes_d;
      segs_q       <= segs_d;
      frame_done_q <= frame_done_d;
    end
  end

  // blank is the only unregistered path: it must darken the panel at once.
  assign anodes     = anodes_q | {NUM_DIGITS{blank}};
  assign segments   = segs_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule
